// File: rtl/arp_rx.sv
// arp_rx: GMII receive ARP parser reporting sender MAC/IP and request/reply type for this board.
// Define ARP_RX_BCAST_EN to also accept broadcast destination MAC.
module arp_rx #(
    parameter logic [47:0] BOARD_MAC = 48'ha0_b1_c2_d3_e1_e1,
    parameter logic [31:0] BOARD_IP  = {8'd192, 8'd168, 8'd1, 8'd11}
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        gmii_rx_dv,
    input  logic [7:0]  gmii_rxd,
    output logic        arp_rx_done,
    output logic        arp_rx_type,
    output logic [47:0] src_mac,
    output logic [31:0] src_ip
);
    typedef enum logic [2:0] {st_idle, st_preamble, st_eth_head, st_arp_data, st_rx_end} state_t;
    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [39:0] sh_q;
    logic [47:0] sh_n;
    logic        err_q;
    logic        dst_ok;
    logic [15:0] op_q;
    logic [47:0] smac_q;
    logic [31:0] sip_q;
    // sh_n is the last six bytes including the one on the bus this cycle
    assign sh_n = {sh_q, gmii_rxd};
`ifdef ARP_RX_BCAST_EN
    assign dst_ok = (sh_n == BOARD_MAC) || (sh_n == 48'hff_ff_ff_ff_ff_ff);
`else
    assign dst_ok = (sh_n == BOARD_MAC);
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= st_idle;
            cnt_q       <= '0;
            sh_q        <= '0;
            err_q       <= 1'b0;
            op_q        <= '0;
            smac_q      <= '0;
            sip_q       <= '0;
            arp_rx_done <= 1'b0;
            arp_rx_type <= 1'b0;
            src_mac     <= '0;
            src_ip      <= '0;
        end else begin
            arp_rx_done <= 1'b0;
            if (gmii_rx_dv) sh_q <= sh_n[39:0];
            case (state_q)
                st_idle: if (gmii_rx_dv) begin
                    state_q <= (gmii_rxd == 8'h55) ? st_preamble : st_rx_end;
                    cnt_q   <= 5'd1;
                end
                st_preamble: if (!gmii_rx_dv) begin
                    state_q <= st_idle;
                    cnt_q   <= '0;
                end else if (cnt_q == 5'd7) begin
                    state_q <= (gmii_rxd == 8'hd5) ? st_eth_head : st_rx_end;
                    cnt_q   <= '0;
                end else if (gmii_rxd != 8'h55) begin
                    state_q <= st_rx_end;
                end else begin
                    cnt_q <= cnt_q + 5'd1;
                end
                st_eth_head: if (!gmii_rx_dv) begin
                    state_q <= st_idle;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd5) err_q <= !dst_ok;
                    if (cnt_q == 5'd13) begin
                        state_q <= (!err_q && sh_n[15:0] == 16'h0806) ? st_arp_data : st_rx_end;
                        cnt_q   <= '0;
                    end
                end
                st_arp_data: if (!gmii_rx_dv) begin
                    state_q <= st_idle;
                    cnt_q   <= '0;
                end else begin
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd7) op_q <= sh_n[15:0];
                    if (cnt_q == 5'd13) smac_q <= sh_n;
                    if (cnt_q == 5'd17) sip_q <= sh_n[31:0];
                    if (cnt_q == 5'd27) begin
                        state_q <= st_rx_end;
                        cnt_q   <= '0;
                        if (sh_n[31:0] == BOARD_IP && (op_q == 16'd1 || op_q == 16'd2)) begin
                            arp_rx_done <= 1'b1;
                            arp_rx_type <= (op_q == 16'd2);
                            src_mac     <= smac_q;
                            src_ip      <= sip_q;
                        end
                    end
                end
                st_rx_end: if (!gmii_rx_dv) begin
                    state_q <= st_idle;
                    cnt_q   <= '0;
                end
                default: state_q <= st_idle;
            endcase
        end
    end
endmodule
